// File: rtl/demux_out2.sv
// Registered 1-to-2 demultiplexer with valid/ready handshakes and a 2-entry FIFO per output.
// Optional per-channel pop counters (cnt0/cnt1) are enabled by defining DEMUX_OUT2_CNT_EN.
module demux_out2 #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  input  logic             in_valid,
  input  logic             in_sel,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1,
  output logic             out1_valid,
  input  logic             out1_ready
`ifdef DEMUX_OUT2_CNT_EN
  ,
  output logic [7:0]       cnt0,
  output logic [7:0]       cnt1
`endif
);

  logic [WIDTH-1:0] mem_q   [2][2];
  logic [1:0]       count_q [2];
  logic             wptr_q  [2];
  logic             rptr_q  [2];
  logic [1:0]       push;
  logic [1:0]       pop;
  logic [1:0]       nonempty;

  assign nonempty = {count_q[1] != 2'd0, count_q[0] != 2'd0};

  // No bypass: a pop in the same cycle never frees a full channel for this push.
  assign in_ready = (count_q[in_sel] != 2'd2);

  assign push = {in_valid & in_ready & in_sel, in_valid & in_ready & ~in_sel};
  assign pop  = {nonempty[1] & out1_ready, nonempty[0] & out0_ready};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        for (int e = 0; e < 2; e++) begin
          mem_q[k][e] <= '0;
        end
        count_q[k] <= 2'd0;
        wptr_q[k]  <= 1'b0;
        rptr_q[k]  <= 1'b0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (push[k]) begin
          mem_q[k][wptr_q[k]] <= in;
          wptr_q[k]           <= ~wptr_q[k];
        end
        if (pop[k]) begin
          rptr_q[k] <= ~rptr_q[k];
        end
        if (push[k] && !pop[k]) begin
          count_q[k] <= count_q[k] + 2'd1;
        end else if (pop[k] && !push[k]) begin
          count_q[k] <= count_q[k] - 2'd1;
        end
      end
    end
  end

  assign out0_valid = nonempty[0];
  assign out1_valid = nonempty[1];
  assign out0       = nonempty[0] ? mem_q[0][rptr_q[0]] : '0;
  assign out1       = nonempty[1] ? mem_q[1][rptr_q[1]] : '0;

`ifdef DEMUX_OUT2_CNT_EN
  logic [7:0] pop_cnt_q [2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pop_cnt_q[0] <= 8'd0;
      pop_cnt_q[1] <= 8'd0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (pop[k]) begin
          pop_cnt_q[k] <= pop_cnt_q[k] + 8'd1;
        end
      end
    end
  end

  assign cnt0 = pop_cnt_q[0];
  assign cnt1 = pop_cnt_q[1];
`endif

endmodule

// File: tb/tb_demux_out2.sv
// Self-checking bench for demux_out2: directed scenarios plus random traffic against
// a per-channel queue model.
module tb_demux_out2;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in;
  logic        in_valid;
  logic        in_sel;
  logic        in_ready;
  logic [15:0] out0;
  logic        out0_valid;
  logic        out0_ready;
  logic [15:0] out1;
  logic        out1_valid;
  logic        out1_ready;
`ifdef DEMUX_OUT2_CNT_EN
  logic [7:0]  cnt0;
  logic [7:0]  cnt1;
`endif

  int errors = 0;
  int checks = 0;

  // Reference model: one queue per channel, plus pop totals.
  logic [15:0] q0[$];
  logic [15:0] q1[$];
  int          pops0 = 0;
  int          pops1 = 0;

  always #5 clk = ~clk;

  demux_out2 #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in        (in),
    .in_valid  (in_valid),
    .in_sel    (in_sel),
    .in_ready  (in_ready),
    .out0      (out0),
    .out0_valid(out0_valid),
    .out0_ready(out0_ready),
    .out1      (out1),
    .out1_valid(out1_valid),
    .out1_ready(out1_ready)
`ifdef DEMUX_OUT2_CNT_EN
    ,
    .cnt0      (cnt0),
    .cnt1      (cnt1)
`endif
  );

  task automatic clear_model();
    q0.delete();
    q1.delete();
    pops0 = 0;
    pops1 = 0;
  endtask

  // Advance one clock edge and apply the handshake rules to the model.
  task automatic tick();
    logic        sel;
    logic [15:0] d;
    logic        rdy;
    logic        psh;
    logic        p0;
    logic        p1;
    sel = in_sel;
    d   = in;
    rdy = sel ? (q1.size() != 2) : (q0.size() != 2);
    psh = in_valid && rdy;
    p0  = (q0.size() != 0) && out0_ready;
    p1  = (q1.size() != 0) && out1_ready;
    @(posedge clk);
    #1;
    if (p0) begin
      void'(q0.pop_front());
      pops0++;
    end
    if (p1) begin
      void'(q1.pop_front());
      pops1++;
    end
    if (psh) begin
      if (sel) q1.push_back(d);
      else     q0.push_back(d);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in = '0; in_valid = 1'b0; in_sel = 1'b0;
    out0_ready = 1'b0; out1_ready = 1'b0;
    #12;
    checks++;
    if (out0_valid !== 1'b0 || out1_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_init: v0=%b v1=%b rdy=%b, want 0 0 1", out0_valid, out1_valid, in_ready);
    end
    checks++;
    if (out0 !== 16'h0 || out1 !== 16'h0) begin
      errors++;
      $display("FAIL reset_init_data: out0=%h out1=%h, want 0 0", out0, out1);
    end
    rst = 1'b0;
    clear_model();
    @(posedge clk); #1;
    in = 16'h0055; in_sel = 1'b0; in_valid = 1'b1; tick();
    in = 16'h0066; in_sel = 1'b1; tick();
    in_valid = 1'b0;
    checks++;
    if (out0_valid !== 1'b1 || out1_valid !== 1'b1 || out0 !== 16'h0055 || out1 !== 16'h0066) begin
      errors++;
      $display("FAIL reset_preload: out0=%h/%b out1=%h/%b, want 0055/1 0066/1",
               out0, out0_valid, out1, out1_valid);
    end
    // Asynchronous reset mid-cycle with both channels holding data.
    #3 rst = 1'b1;
    #1;
    checks++;
    if (out0_valid !== 1'b0 || out1_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_async_valid: v0=%b v1=%b, want 0 0", out0_valid, out1_valid);
    end
    checks++;
    if (out0 !== 16'h0 || out1 !== 16'h0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_async_data: out0=%h out1=%h rdy=%b, want 0 0 1", out0, out1, in_ready);
    end
    clear_model();
    #2 rst = 1'b0;
    in = 16'h0012; in_sel = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out0 !== 16'h0012 || out0_valid !== 1'b1 || out1_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_first_push: out0=%h v0=%b v1=%b, want 0012 1 0",
               out0, out0_valid, out1_valid);
    end
    out0_ready = 1'b1;
    tick();
    out0_ready = 1'b0;
    checks++;
    if (out0_valid !== 1'b0 || out0 !== 16'h0) begin
      errors++;
      $display("FAIL reset_drain: out0=%h v0=%b, want 0000 0", out0, out0_valid);
    end
  endtask

  task automatic test_routing();
    out0_ready = 1'b1; out1_ready = 1'b1;
    in = 16'h0030; in_sel = 1'b1; in_valid = 1'b1;
    tick();
    checks++;
    if (out1 !== 16'h0030 || out1_valid !== 1'b1 || out0_valid !== 1'b0) begin
      errors++;
      $display("FAIL route_sel1: out1=%h v1=%b v0=%b, want 0030 1 0", out1, out1_valid, out0_valid);
    end
    in = 16'h0024; in_sel = 1'b0;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out0 !== 16'h0024 || out0_valid !== 1'b1 || out1_valid !== 1'b0) begin
      errors++;
      $display("FAIL route_sel0: out0=%h v0=%b v1=%b, want 0024 1 0", out0, out0_valid, out1_valid);
    end
    tick();
  endtask

  task automatic test_full();
    out0_ready = 1'b0; out1_ready = 1'b1;
    in_sel = 1'b0; in_valid = 1'b1;
    in = 16'h0001; tick();
    in = 16'h0002; tick();
    in_valid = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_sel0: in_ready=%b, want 0", in_ready);
    end
    in_sel = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL full_sel1: in_ready=%b, want 1", in_ready);
    end
    in_sel = 1'b0;
    out0_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0 || out0 !== 16'h0001) begin
      errors++;
      $display("FAIL full_nobypass: in_ready=%b out0=%h, want 0 0001", in_ready, out0);
    end
    tick();
    checks++;
    if (out0 !== 16'h0002 || out0_valid !== 1'b1) begin
      errors++;
      $display("FAIL full_order: out0=%h v0=%b, want 0002 1", out0, out0_valid);
    end
    tick();
    checks++;
    if (out0_valid !== 1'b0) begin
      errors++;
      $display("FAIL full_empty: v0=%b, want 0", out0_valid);
    end
  endtask

  task automatic test_isolation();
    out0_ready = 1'b0; out1_ready = 1'b0;
    in_sel = 1'b0; in_valid = 1'b1;
    in = 16'h00B1; tick();
    in = 16'h00B2; tick();
    in = 16'h00AA; in_sel = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL iso_ready: in_ready=%b, want 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (out1 !== 16'h00AA || out1_valid !== 1'b1) begin
      errors++;
      $display("FAIL iso_out1: out1=%h v1=%b, want 00aa 1", out1, out1_valid);
    end
    checks++;
    if (out0 !== 16'h00B1 || out0_valid !== 1'b1) begin
      errors++;
      $display("FAIL iso_ch0_kept: out0=%h v0=%b, want 00b1 1", out0, out0_valid);
    end
    out0_ready = 1'b1; out1_ready = 1'b1;
    tick();
    checks++;
    if (out0 !== 16'h00B2 || out1_valid !== 1'b0) begin
      errors++;
      $display("FAIL iso_ch0_second: out0=%h v1=%b, want 00b2 0", out0, out1_valid);
    end
    tick();
  endtask

  task automatic test_random();
    int          accepted = 0;
    int          cyc = 0;
    bit          hold = 0;
    logic        exp_rdy;
    logic [15:0] exp0;
    logic [15:0] exp1;
    while (accepted < 100 && cyc < 3000) begin
      if (!hold) begin
        in_valid = ($urandom % 4) != 0;
        in       = 16'($urandom);
        in_sel   = ($urandom % 4) != 0;
      end
      out0_ready = ($urandom % 2) == 1;
      out1_ready = ($urandom % 4) != 0;
      #1;
      exp_rdy = in_sel ? (q1.size() != 2) : (q0.size() != 2);
      exp0    = (q0.size() != 0) ? q0[0] : 16'h0;
      exp1    = (q1.size() != 0) ? q1[0] : 16'h0;
      checks++;
      if (in_ready !== exp_rdy) begin
        errors++;
        $display("FAIL rand_ready cyc%0d: in_ready=%b, want %b", cyc, in_ready, exp_rdy);
      end
      checks++;
      if (out0_valid !== (q0.size() != 0) || out0 !== exp0) begin
        errors++;
        $display("FAIL rand_ch0 cyc%0d: out0=%h v0=%b, want %h %b",
                 cyc, out0, out0_valid, exp0, q0.size() != 0);
      end
      checks++;
      if (out1_valid !== (q1.size() != 0) || out1 !== exp1) begin
        errors++;
        $display("FAIL rand_ch1 cyc%0d: out1=%h v1=%b, want %h %b",
                 cyc, out1, out1_valid, exp1, q1.size() != 0);
      end
      if (in_valid && exp_rdy) accepted++;
      hold = in_valid && !exp_rdy;
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    checks++;
    if (accepted < 100) begin
      errors++;
      $display("FAIL rand_timeout: accepted=%0d, want 100", accepted);
    end
    out0_ready = 1'b1; out1_ready = 1'b1;
    repeat (3) tick();
    checks++;
    if (out0_valid !== 1'b0 || out1_valid !== 1'b0 || q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL rand_drain: v0=%b v1=%b, want 0 0", out0_valid, out1_valid);
    end
  endtask

`ifdef DEMUX_OUT2_CNT_EN
  task automatic test_cnt();
    #3 rst = 1'b1;
    #1 rst = 1'b0;
    clear_model();
    checks++;
    if (cnt0 !== 8'd0 || cnt1 !== 8'd0) begin
      errors++;
      $display("FAIL cnt_reset: cnt0=%0d cnt1=%0d, want 0 0", cnt0, cnt1);
    end
    out0_ready = 1'b1; out1_ready = 1'b1;
    in_sel = 1'b0; in_valid = 1'b1;
    repeat (256) begin
      in = 16'($urandom);
      tick();
      if (pops0 == 128) begin
        checks++;
        if (cnt0 !== 8'd128) begin
          errors++;
          $display("FAIL cnt_mid: cnt0=%0d, want 128", cnt0);
        end
      end
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (pops0 != 256 || cnt0 !== 8'(pops0 % 256)) begin
      errors++;
      $display("FAIL cnt_wrap: cnt0=%0d pops=%0d, want 0 after 256 pops", cnt0, pops0);
    end
    checks++;
    if (cnt1 !== 8'd0) begin
      errors++;
      $display("FAIL cnt1_still: cnt1=%0d, want 0", cnt1);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_routing();
    test_full();
    test_isolation();
    test_random();
`ifdef DEMUX_OUT2_CNT_EN
    test_cnt();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/demux_out2.md
Name: demux_out2

Overview:
- Registered 1-to-2 demultiplexer with valid/ready handshakes; the inverse of the GCD datapath's 2:1 operand mux.
- Takes one WIDTH-bit stream and steers each word to output 0 or 1 according to a per-word select.
- Each output has its own 2-entry buffer, so a stalled consumer never blocks the other channel once that channel has space.
- Sits between the GCD result path and two downstream consumers, e.g. a result register and a debug/readback port.

Parameters:
- WIDTH, 16, data width of the input and of both outputs.

Ports:
- clk  input  1  system clock; all state changes on the rising edge
- rst  input  1  asynchronous, active-high reset
- in  input  WIDTH  input data word
- in_valid  input  1  in carries a valid word
- in_sel  input  1  destination of the current word: 0 -> out0, 1 -> out1
- in_ready  output  1  block accepts the current word this cycle
- out0  output  WIDTH  channel 0 head data
- out0_valid  output  1  out0 holds a valid word
- out0_ready  input  1  channel 0 consumer accepts out0
- out1  output  WIDTH  channel 1 head data
- out1_valid  output  1  out1 holds a valid word
- out1_ready  input  1  channel 1 consumer accepts out1

Behaviour:
- Reset (asynchronous, rst=1): both channel buffers empty; occupancy counts = 0; out0 = out1 = 0; out0_valid = out1_valid = 0. Clearing mid-transfer discards all buffered words, with no partial state left.
- Channel k buffer: 2-entry FIFO; 2-bit occupancy count (0..2); write pointer and read pointer of 1 bit each, wrapping 1 -> 0.
- outK = entry at the read pointer, and is 0 when the buffer is empty. outK_valid = (countK != 0).
- in_ready = (count[in_sel] != 2). It is combinational on in_sel and the counts, and never depends on in_valid.
- Push: in_valid && in_ready at a clock edge writes in into buffer[in_sel] at the write pointer, then advances that pointer.
- Pop: outK_valid && outK_ready at an edge advances read pointer K.
- Count update per channel: push only -> +1; pop only -> -1; push and pop together -> unchanged; neither -> unchanged.
- Latency: a word accepted at edge N appears on outK with outK_valid=1 after edge N (one cycle). There is no combinational path from in to out.
- Full channel (count = 2): in_ready=0 only while in_sel selects that channel. No bypass: a pop in the same cycle does not make in_ready high.
- Empty channel: outK_ready is ignored and no pop occurs.
- Ordering is preserved within each channel. There is no ordering relation between the two channels.
- Holding rule: while outK_valid=1 and outK_ready=0, outK and outK_valid stay stable.
- Upstream rule: in and in_sel must be held while in_valid=1 and in_ready=0.

Optional Feature:
- Macro DEMUX_OUT2_CNT_EN.
- When defined, two extra outputs are added: cnt0 and cnt1, each output 8 bits.
  - cntK increments on every pop of channel K and wraps 255 -> 0.
  - Both counters reset to 0 on rst.
- When not defined, these ports and registers do not exist and behaviour is otherwise identical.

Test Plan:
- Reset: assert rst mid-cycle with both channels holding data -> immediately out0_valid=out1_valid=0, out0=out1=0, in_ready=1. After release, push 16'h0012 sel=0 -> out0=16'h0012, out0_valid=1 one cycle later.
- Routing: push 16'h0030 sel=1, then 16'h0024 sel=0, with both readys held 1 -> out1=16'h0030 at cycle 1, out0=16'h0024 at cycle 2; the other valid stays 0 in each cycle.
- Full and backpressure: out0_ready=0; push 16'h0001, 16'h0002 sel=0 -> in_ready=0 with sel=0, in_ready=1 with sel=1. Raise out0_ready -> out0 shows 0001 then 0002 in order.
- Isolation: channel 0 full and stalled; push 16'h00AA sel=1 -> accepted, out1=16'h00AA next cycle, channel 0 contents unchanged.
- Simultaneous push and pop at count=1 on channel 1 -> count stays 1, head advances to the next word, no loss or duplication over 100 random words checked against a scoreboard.
- With DEMUX_OUT2_CNT_EN defined: pop 256 words on channel 0 -> cnt0 wraps to 0 and cnt1 is unchanged.
